// File: rtl/sram_burst_reader_pkg.sv
// Shared constants and types for the SRAM burst reader and its output FIFO.
package sram_burst_reader_pkg;

  localparam int unsigned INTERNAL_BITS = 16;
  localparam int unsigned STATE_BITS    = 2;

  localparam logic [STATE_BITS-1:0] READER_IDLE  = 2'd0;
  localparam logic [STATE_BITS-1:0] READER_READ  = 2'd1;
  localparam logic [STATE_BITS-1:0] READER_DRAIN = 2'd2;
  localparam logic [STATE_BITS-1:0] READER_DONE  = 2'd3;

  // One buffered stream beat: the SRAM word plus its end-of-burst marker.
  typedef struct packed {
    logic                     last;
    logic [INTERNAL_BITS-1:0] data;
  } stream_word_t;

endpackage

// File: rtl/sram_burst_reader_sync_fifo_2.sv
// Small register FIFO with push/pop, occupancy count and a head output.
module sync_fifo_2 #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign count = count_q;
  assign head  = mem[rd_ptr];

  // Simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem     <= '{default: '0};
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_burst_reader.sv
// Sequential burst reader for the SRAM read port; turns the 1-cycle read
// latency into a valid/ready stream with a last flag.
module sram_burst_reader
  import sram_burst_reader_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = 13,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_BITS-1:0]     base_addr,
  input  logic [ADDR_BITS:0]       length,
  output logic                     busy,
  output logic                     done,
  output logic                     sram_cen,
  output logic [ADDR_BITS-1:0]     sram_addr,
  input  logic [INTERNAL_BITS-1:0] sram_q,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INTERNAL_BITS-1:0] out_data,
  output logic                     out_last
);

  localparam int unsigned LEN_W = ADDR_BITS + 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [STATE_BITS-1:0] state;
  logic [STATE_BITS-1:0] state_next;
  logic [ADDR_BITS-1:0]  rd_ptr;
  logic [LEN_W-1:0]      remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic [CNT_W-1:0]      fifo_count;
  logic [OCC_W-1:0]      occupancy;
  stream_word_t          push_word;
  stream_word_t          head_word;
  logic                  pop;
  logic                  issue;
  logic                  last_issue;

  // Buffered words plus the read still on its way back from the SRAM.
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight);
  assign push_word = '{last: inflight_last, data: sram_q};

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = head_word.data;
  assign out_last  = out_valid && head_word.last;
  assign sram_addr = rd_ptr;
  assign sram_cen  = issue;

  // Issue only when the word is guaranteed a FIFO slot on arrival.
  always_comb begin
    issue = 1'b0;
    if (state == READER_READ && remaining != '0) begin
      if (occupancy < OCC_W'(FIFO_DEPTH)) begin
        issue = 1'b1;
      end else if (occupancy == OCC_W'(FIFO_DEPTH) && pop) begin
        issue = 1'b1;
      end
    end
  end

  assign last_issue = issue && (remaining == LEN_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= READER_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      READER_IDLE: begin
        if (start) begin
          state_next = (length == '0) ? READER_DONE : READER_READ;
        end
      end
      READER_READ: begin
        busy = 1'b1;
        if (last_issue) begin
          state_next = READER_DRAIN;
        end
      end
      READER_DRAIN: begin
        busy = 1'b1;
        if (pop && head_word.last) begin
          state_next = READER_DONE;
        end
      end
      READER_DONE: begin
        done       = 1'b1;
        state_next = READER_IDLE;
      end
      default: begin
        state_next = READER_IDLE;
      end
    endcase
  end

  // Read pointer wraps naturally at 2^ADDR_BITS.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= last_issue;
      if (state == READER_IDLE && start && length != '0) begin
        rd_ptr    <= base_addr;
        remaining <= length;
      end else if (issue) begin
        rd_ptr    <= rd_ptr + ADDR_BITS'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

  sync_fifo_2 #(
    .WIDTH ($bits(stream_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (push_word),
    .pop       (pop),
    .count     (fifo_count),
    .head      (head_word)
  );

endmodule
